// File: rtl/mult_share_sched.sv
// Round-robin sharing of one matrix-multiply engine between two requesters.
// Grants a job, pulses eng_start, then waits for eng_done under a watchdog.
module mult_share_sched #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024,
    parameter int TMO_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          eng_start,
    output logic          eng_rst,
    output logic [DW-1:0] eng_data_in,
    input  logic [DW-1:0] eng_data_out,
    input  logic          eng_done,
    output logic [DW-1:0] data_out,
    output logic          done0,
    output logic          done1,
    output logic          timeout,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_START, S_RUN, S_RELEASE
    } state_e;

    // Terminal count of the watchdog; only meaningful when TIMEOUT != 0.
    localparam logic [TMO_W-1:0] TC = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               sel_q, sel_d;
    logic               abort_q, abort_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        abort_d = abort_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie, serve whoever did not go last.
                    sel_d   = (req0 && req1) ? ~last_q : req1;
                    abort_d = 1'b0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: state_d = S_START;
            S_START: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (eng_done) begin
                    abort_d = 1'b0;
                    state_d = S_RELEASE;
                end else if ((TIMEOUT != 0) && (cnt_q == TC)) begin
                    abort_d = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        gnt0        = busy && !sel_q;
        gnt1        = busy &&  sel_q;
        eng_start   = (state_q == S_START);
        done0       = (state_q == S_RELEASE) && !abort_q && !sel_q;
        done1       = (state_q == S_RELEASE) && !abort_q &&  sel_q;
        timeout     = (state_q == S_RELEASE) &&  abort_q;
        eng_rst     = rst || timeout;
        eng_data_in = busy ? (sel_q ? data_in1 : data_in0) : '0;
        data_out    = busy ? eng_data_out : '0;
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench: dut_a uses TIMEOUT=1024, dut_b uses TIMEOUT=16, both on shared inputs.
module tb_mult_share_sched;

    localparam int DW = 8;

    logic          clk, rst, req0, req1, eng_done;
    logic [DW-1:0] data_in0, data_in1, eng_data_out;

    logic          a_gnt0, a_gnt1, a_eng_start, a_eng_rst, a_done0, a_done1, a_timeout, a_busy;
    logic [DW-1:0] a_eng_data_in, a_data_out;
    logic          b_gnt0, b_gnt1, b_eng_start, b_eng_rst, b_done0, b_done1, b_timeout, b_busy;
    logic [DW-1:0] b_eng_data_in, b_data_out;

    int n_vec = 0;
    int n_err = 0;

    mult_share_sched #(.DW(DW), .TIMEOUT(1024), .TMO_W(16)) dut_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data_in0(data_in0), .data_in1(data_in1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .eng_start(a_eng_start), .eng_rst(a_eng_rst),
        .eng_data_in(a_eng_data_in), .eng_data_out(eng_data_out), .eng_done(eng_done),
        .data_out(a_data_out), .done0(a_done0), .done1(a_done1),
        .timeout(a_timeout), .busy(a_busy)
    );

    mult_share_sched #(.DW(DW), .TIMEOUT(16), .TMO_W(16)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data_in0(data_in0), .data_in1(data_in1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .eng_start(b_eng_start), .eng_rst(b_eng_rst),
        .eng_data_in(b_eng_data_in), .eng_data_out(eng_data_out), .eng_done(eng_done),
        .data_out(b_data_out), .done0(b_done0), .done1(b_done1),
        .timeout(b_timeout), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and overlap detector, sampled mid-cycle.
    int   a_d0_n = 0, a_d1_n = 0, a_to_n = 0, b_d0_n = 0, b_d1_n = 0, b_to_n = 0;
    logic both_hi = 1'b0;
    always @(negedge clk) begin
        if (a_done0 === 1'b1) a_d0_n++;
        if (a_done1 === 1'b1) a_d1_n++;
        if (a_timeout === 1'b1) a_to_n++;
        if (b_done0 === 1'b1) b_d0_n++;
        if (b_done1 === 1'b1) b_d1_n++;
        if (b_timeout === 1'b1) b_to_n++;
        if ((a_gnt0 & a_gnt1) === 1'b1 || (b_gnt0 & b_gnt1) === 1'b1) both_hi = 1'b1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_gnt0"}, a_gnt0, 1'b0);
        chk1({tag, "_gnt1"}, a_gnt1, 1'b0);
        chk1({tag, "_start"}, a_eng_start, 1'b0);
        chk1({tag, "_done0"}, a_done0, 1'b0);
        chk1({tag, "_done1"}, a_done1, 1'b0);
        chk1({tag, "_timeout"}, a_timeout, 1'b0);
        chk1({tag, "_busy"}, a_busy, 1'b0);
        chk8({tag, "_eng_din"}, a_eng_data_in, 8'h00);
        chk8({tag, "_dout"}, a_data_out, 8'h00);
        chk1({tag, "_b_busy"}, b_busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; eng_done = 1'b0;
        data_in0 = 8'h3C; data_in1 = 8'hA5; eng_data_out = 8'h7E;
        #1;
        chk1("rst_eng_rst_comb", a_eng_rst, 1'b1);

        // Reset state
        step();
        chk_quiet("reset");
        chk1("reset_eng_rst", a_eng_rst, 1'b1);
        rst = 1'b0;
        step();
        chk1("idle_eng_rst", a_eng_rst, 1'b0);
        chk1("idle_busy", a_busy, 1'b0);

        // Single request on req0, done 40 cycles after start
        req0 = 1'b1;
        step();
        chk1("t1_gnt0", a_gnt0, 1'b1);
        chk1("t1_gnt1", a_gnt1, 1'b0);
        chk1("t1_busy", a_busy, 1'b1);
        chk1("t1_nostart", a_eng_start, 1'b0);
        req0 = 1'b0;
        step();
        chk1("t1_start", a_eng_start, 1'b1);
        chk1("t1_gnt0_held", a_gnt0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0) chk1("t1_start_one_cycle", a_eng_start, 1'b0);
            if (i == 16) begin
                chk1("t1_b_wd_timeout", b_timeout, 1'b1);
                chk1("t1_b_wd_done0", b_done0, 1'b0);
            end
        end
        chk1("t1_no_early_done", a_done0, 1'b0);
        chk1("t1_still_busy", a_busy, 1'b1);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk1("t1_done0", a_done0, 1'b1);
        chk1("t1_done1", a_done1, 1'b0);
        chk1("t1_timeout", a_timeout, 1'b0);
        chk1("t1_eng_rst", a_eng_rst, 1'b0);
        chk1("t1_rel_gnt0", a_gnt0, 1'b1);
        step();
        chk1("t1_idle_done0", a_done0, 1'b0);
        chk1("t1_idle_busy", a_busy, 1'b0);
        chk1("t1_idle_gnt0", a_gnt0, 1'b0);

        // Watchdog on dut_b: engine never done
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        step();
        chk1("t2_start", b_eng_start, 1'b1);
        for (int i = 0; i < 16; i++) step();
        chk1("t2_run16_busy", b_busy, 1'b1);
        chk1("t2_run16_no_timeout", b_timeout, 1'b0);
        step();
        chk1("t2_timeout", b_timeout, 1'b1);
        chk1("t2_eng_rst", b_eng_rst, 1'b1);
        chk1("t2_done0", b_done0, 1'b0);
        chk1("t2_gnt0", b_gnt0, 1'b1);
        step();
        chk1("t2_idle_busy", b_busy, 1'b0);
        chk1("t2_idle_timeout", b_timeout, 1'b0);
        chk1("t2_idle_eng_rst", b_eng_rst, 1'b0);
        chk1("t2_a_still_busy", a_busy, 1'b1);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk1("t2_a_done0", a_done0, 1'b1);
        step();

        // Done in terminal-count cycle, plus data steering on gnt1
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        chk1("t3_gnt1", b_gnt1, 1'b1);
        chk1("t3_gnt0", b_gnt0, 1'b0);
        chk8("t3_eng_din", b_eng_data_in, 8'hA5);
        chk8("t3_dout", b_data_out, 8'h7E);
        chk8("t3_a_eng_din", a_eng_data_in, 8'hA5);
        step();
        for (int i = 0; i < 16; i++) step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk1("t3_done1", b_done1, 1'b1);
        chk1("t3_timeout", b_timeout, 1'b0);
        chk1("t3_eng_rst", b_eng_rst, 1'b0);
        step();
        chk8("t3_idle_eng_din", b_eng_data_in, 8'h00);
        chk8("t3_idle_dout", b_data_out, 8'h00);

        // Round robin with both requesting: order 0,1,0
        req0 = 1'b1; req1 = 1'b1;
        step();
        for (int j = 0; j < 3; j++) begin
            chk1("t4_gnt0", a_gnt0, (j != 1));
            chk1("t4_gnt1", a_gnt1, (j == 1));
            step();
            chk1("t4_start", a_eng_start, 1'b1);
            step();
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
            chk1("t4_done0", a_done0, (j != 1));
            chk1("t4_done1", a_done1, (j == 1));
            if (j == 2) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            step();
            chk1("t4_idle_gap", a_busy, 1'b0);
            if (j < 2) step();
        end

        // Reset mid-RUN; afterwards req0 wins the tie again
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        chk1("t5_gnt1", a_gnt1, 1'b1);
        step();
        for (int i = 0; i < 10; i++) step();
        chk1("t5_running", a_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("t5_eng_rst_a", a_eng_rst, 1'b1);
        chk1("t5_eng_rst_b", b_eng_rst, 1'b1);
        step();
        chk_quiet("t5_after_rst");
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        step();
        req0 = 1'b0; req1 = 1'b0;
        chk1("t5_tie_gnt0", a_gnt0, 1'b1);
        chk1("t5_tie_gnt1", a_gnt1, 1'b0);
        step();
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk1("t5_done0", a_done0, 1'b1);
        step();
        chk1("t5_idle", a_busy, 1'b0);

        // Totals of every pulse seen over the run
        chkn("a_done0_pulses", a_d0_n, 5);
        chkn("a_done1_pulses", a_d1_n, 2);
        chkn("a_timeout_pulses", a_to_n, 0);
        chkn("b_done0_pulses", b_d0_n, 3);
        chkn("b_done1_pulses", b_d1_n, 2);
        chkn("b_timeout_pulses", b_to_n, 2);
        chk1("gnt_overlap", both_hi, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
